// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run controller: state encodings and default timing constants.
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_HALTED   = 2'd1,
        ST_RUN      = 2'd2,
        ST_STEP     = 2'd3
    } state_t;

    localparam int          DIV_W_DEF      = 24;
    localparam logic [23:0] DIV_MAX_DEF    = 24'd12_499_999;
    localparam logic [3:0]  RST_CYCLES_DEF = 4'd8;

endpackage

// File: rtl/cpu_run_ctrl_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a registered rising-edge pulse.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic meta_q;
    logic sync_q;
    logic sync_d_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            sync_d_q <= 1'b0;
            pulse    <= 1'b0;
        end else begin
            meta_q   <= din;
            sync_q   <= meta_q;
            sync_d_q <= sync_q;
            pulse    <= sync_q & ~sync_d_q;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Execution sequencer: turns VIO run/step/halt/reset requests into a one-cycle CPU clock enable,
// a held CPU reset, and a PC breakpoint stop.
//
// state       | meaning
// ST_RST_HOLD | cpu_reset held for RST_CYCLES clocks, no enables
// ST_HALTED   | idle, waiting for run or step
// ST_RUN      | enable pulse each time the tick counter wraps
// ST_STEP     | single enable pulse, then back to halted
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int               DIV_W      = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DIV_MAX    = DIV_W'(DIV_MAX_DEF),
    parameter logic [3:0]       RST_CYCLES = RST_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_req,
    input  logic        step_req,
    input  logic        halt_req,
    input  logic        cpu_rst_req,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    output logic        cpu_ce,
    output logic        cpu_reset,
    output logic        halted,
    output logic        bp_hit,
    output logic [1:0]  state,
    output logic [31:0] ce_count
);

    logic run_ev, step_ev, halt_ev, rst_ev;

    sync_edge u_sync_run  (.clk(clk), .reset(reset), .din(run_req),     .pulse(run_ev));
    sync_edge u_sync_step (.clk(clk), .reset(reset), .din(step_req),    .pulse(step_ev));
    sync_edge u_sync_halt (.clk(clk), .reset(reset), .din(halt_req),    .pulse(halt_ev));
    sync_edge u_sync_rst  (.clk(clk), .reset(reset), .din(cpu_rst_req), .pulse(rst_ev));

    state_t           state_q, state_nxt;
    logic [3:0]       rst_cnt_q, rst_cnt_nxt;
    logic [DIV_W-1:0] tick_q, tick_nxt;
    logic             skip_q, skip_nxt;
    logic             ce_q, ce_nxt;
    logic             bp_hit_q, bp_hit_nxt;
    logic [31:0]      count_q, count_nxt;
    logic             cpu_reset_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RST_HOLD;
            rst_cnt_q   <= '0;
            tick_q      <= '0;
            skip_q      <= 1'b0;
            ce_q        <= 1'b0;
            bp_hit_q    <= 1'b0;
            count_q     <= '0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_nxt;
            rst_cnt_q   <= rst_cnt_nxt;
            tick_q      <= tick_nxt;
            skip_q      <= skip_nxt;
            ce_q        <= ce_nxt;
            bp_hit_q    <= bp_hit_nxt;
            count_q     <= count_nxt;
            cpu_reset_q <= (state_nxt == ST_RST_HOLD);
        end
    end

    always_comb begin
        state_nxt   = state_q;
        rst_cnt_nxt = rst_cnt_q;
        tick_nxt    = '0;
        skip_nxt    = skip_q;
        ce_nxt      = 1'b0;
        bp_hit_nxt  = bp_hit_q;
        count_nxt   = count_q;

        if (ce_q && (count_q != '1)) begin
            count_nxt = count_q + 32'd1;
        end

        // CPU reset request outranks everything, including a pulse already in flight.
        if (rst_ev && (state_q != ST_RST_HOLD)) begin
            state_nxt   = ST_RST_HOLD;
            rst_cnt_nxt = '0;
            count_nxt   = '0;
            bp_hit_nxt  = 1'b0;
        end else begin
            unique case (state_q)
                ST_RST_HOLD: begin
                    rst_cnt_nxt = rst_cnt_q + 4'd1;
                    if (rst_cnt_q == RST_CYCLES - 4'd1) begin
                        state_nxt = ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    if (step_ev) begin
                        state_nxt  = ST_STEP;
                        ce_nxt     = 1'b1;
                        bp_hit_nxt = 1'b0;
                    end else if (run_ev) begin
                        state_nxt  = ST_RUN;
                        skip_nxt   = 1'b1;
                        bp_hit_nxt = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (halt_ev) begin
                        state_nxt = ST_HALTED;
                    end else if (tick_q == DIV_MAX) begin
                        // skip_bp lets a resume step off the instruction it stopped on.
                        if (bp_en && (pc == bp_addr) && !skip_q) begin
                            state_nxt  = ST_HALTED;
                            bp_hit_nxt = 1'b1;
                        end else begin
                            ce_nxt   = 1'b1;
                            skip_nxt = 1'b0;
                        end
                    end else begin
                        tick_nxt = tick_q + 1'b1;
                    end
                end
                ST_STEP: begin
                    state_nxt = ST_HALTED;
                end
            endcase
        end
    end

    assign cpu_ce    = ce_q;
    assign cpu_reset = cpu_reset_q;
    assign halted    = (state_q == ST_HALTED);
    assign bp_hit    = bp_hit_q;
    assign state     = state_q;
    assign ce_count  = count_q;

endmodule
